// File: rtl/div_iter_if.sv
// Request/response bundle for the iterative divider.
// Signal names match the divider's original port list so existing hookups map one-to-one.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, result = {remainder, quotient}.
// Define DIV_ITER_EARLY_TERM_EN to finish in 2 cycles when |dividend| < |divisor|.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int WW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WW-1:0]      r_work;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_sign_q;
  logic               r_sign_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  logic               w_op1_neg;
  logic               w_op2_neg;
  logic [WIDTH-1:0]   w_op1_mag;
  logic [WIDTH-1:0]   w_op2_mag;
  logic [WIDTH+1:0]   w_upper;
  logic [WIDTH+1:0]   w_diff;
  logic               w_fits;
  logic [WW-1:0]      w_step;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign w_op2_mag = w_op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

  // Partial remainder after the left shift, one guard bit wide so the borrow
  // of the trial subtraction lands in w_diff's MSB.
  assign w_upper = r_work[WW-1:WIDTH-1];
  assign w_diff  = w_upper - {2'b00, r_divisor};
  assign w_fits  = ~w_diff[WIDTH+1];
  assign w_step  = w_fits ? {w_diff[WIDTH:0], r_work[WIDTH-2:0], 1'b1}
                          : {r_work[WW-2:0], 1'b0};

  assign w_quot     = r_work[WIDTH-1:0];
  assign w_rem      = r_work[2*WIDTH-1:WIDTH];
  assign w_quot_fix = r_sign_q ? (~w_quot + 1'b1) : w_quot;
  assign w_rem_fix  = r_sign_r ? (~w_rem + 1'b1) : w_rem;

`ifdef DIV_ITER_EARLY_TERM_EN
  logic w_early;
  assign w_early = (w_op1_mag < w_op2_mag);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          if (bus.start_i && !bus.annul_i) begin
            r_work    <= {{(WIDTH+1){1'b0}}, w_op1_mag};
            r_divisor <= w_op2_mag;
            r_sign_q  <= w_op1_neg ^ w_op2_neg;
            r_sign_r  <= w_op1_neg;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            if (bus.opdata2_i == '0) begin
              r_state <= BYZERO;
`ifdef DIV_ITER_EARLY_TERM_EN
            end else if (w_early) begin
              // ready_o follows one cycle later from END, giving the 2-cycle latency
              r_state  <= END;
              r_result <= {bus.opdata1_i, {WIDTH{1'b0}}};
`endif
            end else begin
              r_state <= ON;
            end
          end
        end

        BYZERO: begin
          if (bus.annul_i) begin
            r_state  <= FREE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
            r_work   <= '0;
          end else begin
            r_state  <= END;
            r_result <= '0;
            r_ready  <= 1'b1;
          end
        end

        ON: begin
          if (bus.annul_i) begin
            r_state  <= FREE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
          end else if (r_cnt == LAST) begin
            // All WIDTH steps done; this extra cycle applies the sign fix-up
            r_state  <= END;
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= 1'b1;
          end else begin
            r_work <= w_step;
            r_cnt  <= r_cnt + 1'b1;
          end
        end

        END: begin
          if (!bus.start_i) begin
            r_state  <= FREE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
          end else begin
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state  <= FREE;
          r_busy   <= 1'b0;
          r_ready  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
  assign bus.busy_o   = r_busy;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter at WIDTH 8, 32 and 64 against an arithmetic reference.
// Honours DIV_ITER_EARLY_TERM_EN when it is defined for the build.
module tb_div_iter;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(8))  b8  ();
  div_iter_if #(.WIDTH(32)) b32 ();
  div_iter_if #(.WIDTH(64)) b64 ();

  div_iter #(.WIDTH(8))  u_div8  (.clk(clk), .rst(rst), .bus(b8.slave));
  div_iter #(.WIDTH(32)) u_div32 (.clk(clk), .rst(rst), .bus(b32.slave));
  div_iter #(.WIDTH(64)) u_div64 (.clk(clk), .rst(rst), .bus(b64.slave));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] mag(input int w, input bit sgn, input logic [63:0] v);
    logic [63:0] m;
    m = wmask(w);
    if (sgn && v[w-1]) return (~v + 64'd1) & m;
    return v & m;
  endfunction

  // Truncating division with C-style signs; divide by zero gives all zeros.
  function automatic logic [127:0] model(input int w, input bit sgn, input logic [63:0] a_in,
                                         input logic [63:0] b_in);
    logic [63:0] m, a, b, q, r, t;
    longint sa, sb;
    m = wmask(w);
    a = a_in & m;
    b = b_in & m;
    if (b == 0) return '0;
    if (sgn) begin
      t  = a << (64 - w);
      sa = $signed(t) >>> (64 - w);
      t  = b << (64 - w);
      sb = $signed(t) >>> (64 - w);
      if (sb == -1) begin
        q = ~a + 64'd1;
        r = '0;
      end else begin
        q = 64'(sa / sb);
        r = 64'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return (128'(r & m) << w) | 128'(q & m);
  endfunction

  function automatic int exp_lat(input int w, input bit sgn, input logic [63:0] a,
                                 input logic [63:0] b);
    if ((b & wmask(w)) == 0) return 2;
`ifdef DIV_ITER_EARLY_TERM_EN
    if (mag(w, sgn, a) < mag(w, sgn, b)) return 2;
`endif
    return w + 2;
  endfunction

  function automatic logic [63:0] rnd_op(input int w, input bit is_divisor);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: v = is_divisor ? 64'd0 : v;
      1: v = '1;
      2: v = 64'd1 << (w - 1);
      3: v = 64'($urandom_range(1, 9));
      4: v = ~64'($urandom_range(0, 8));
      5: v = v >> $urandom_range(1, w - 1);
      default: ;
    endcase
    return v & wmask(w);
  endfunction

  task automatic op32(input string tag, input bit sgn, input logic [31:0] a,
                      input logic [31:0] b, output logic [63:0] res);
    int lat;
    lat = 0;
    b32.signed_div_i = sgn;
    b32.opdata1_i    = a;
    b32.opdata2_i    = b;
    b32.start_i      = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        b32.opdata1_i    = $urandom;
        b32.opdata2_i    = $urandom;
        b32.signed_div_i = ~sgn;
      end
    end while (!b32.ready_o && lat < 300);
    res = b32.result_o;
    check({tag, " latency"}, 128'(lat), 128'(exp_lat(32, sgn, 64'(a), 64'(b))));
    check({tag, " result"}, 128'(res), model(32, sgn, 64'(a), 64'(b)));
    b32.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle"}, 128'({b32.busy_o, b32.ready_o, b32.result_o}), '0);
  endtask

  task automatic op8(input string tag, input bit sgn, input logic [7:0] a, input logic [7:0] b);
    int lat;
    lat = 0;
    b8.signed_div_i = sgn;
    b8.opdata1_i    = a;
    b8.opdata2_i    = b;
    b8.start_i      = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        b8.opdata1_i = 8'($urandom);
        b8.opdata2_i = 8'($urandom);
      end
    end while (!b8.ready_o && lat < 300);
    check({tag, " latency"}, 128'(lat), 128'(exp_lat(8, sgn, 64'(a), 64'(b))));
    check({tag, " result"}, 128'(b8.result_o), model(8, sgn, 64'(a), 64'(b)));
    b8.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle"}, 128'({b8.busy_o, b8.ready_o, b8.result_o}), '0);
  endtask

  task automatic op64(input string tag, input bit sgn, input logic [63:0] a,
                      input logic [63:0] b);
    int lat;
    lat = 0;
    b64.signed_div_i = sgn;
    b64.opdata1_i    = a;
    b64.opdata2_i    = b;
    b64.start_i      = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        b64.opdata1_i = {$urandom, $urandom};
        b64.opdata2_i = {$urandom, $urandom};
      end
    end while (!b64.ready_o && lat < 300);
    check({tag, " latency"}, 128'(lat), 128'(exp_lat(64, sgn, a, b)));
    check({tag, " result"}, b64.result_o, model(64, sgn, a, b));
    b64.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle"}, {b64.busy_o, b64.ready_o, b64.result_o}, '0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    logic [63:0] a, b;
    logic        saw_ready;
    bit          s;

    rst = 1'b0;
    b8.signed_div_i  = 1'b0; b8.opdata1_i  = '0; b8.opdata2_i  = '0; b8.start_i  = 1'b0; b8.annul_i  = 1'b0;
    b32.signed_div_i = 1'b0; b32.opdata1_i = '0; b32.opdata2_i = '0; b32.start_i = 1'b0; b32.annul_i = 1'b0;
    b64.signed_div_i = 1'b0; b64.opdata1_i = '0; b64.opdata2_i = '0; b64.start_i = 1'b0; b64.annul_i = 1'b0;

    #1;
    check("reset32", 128'({b32.busy_o, b32.ready_o, b32.result_o}), '0);
    check("reset8_64", {b8.busy_o, b8.ready_o, b64.busy_o, b64.ready_o, b8.result_o, b64.result_o}, '0);
    #11 rst = 1'b1;
    @(posedge clk); #1;

    // start together with annul in FREE must not launch anything
    b32.opdata1_i = 32'd100; b32.opdata2_i = 32'd7;
    b32.start_i = 1'b1; b32.annul_i = 1'b1;
    @(posedge clk); #1;
    check("start_with_annul", 128'({b32.busy_o, b32.ready_o}), '0);
    b32.start_i = 1'b0; b32.annul_i = 1'b0;
    @(posedge clk); #1;

    op32("u100/7", 1'b0, 32'd100, 32'd7, res);
    check("u100/7 const", 128'(res), 128'(64'h00000002_0000000E));
    op32("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, res);
    check("s-7/2 const", 128'(res), 128'(64'hFFFFFFFF_FFFFFFFD));
    op32("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, res);
    check("s7/-2 const", 128'(res), 128'(64'h00000001_FFFFFFFD));
    op32("div0", 1'b0, 32'h1234, 32'd0, res);
    check("div0 const", 128'(res), '0);
`ifdef DIV_ITER_EARLY_TERM_EN
    op32("early3/5", 1'b0, 32'd3, 32'd5, res);
    check("early3/5 const", 128'(res), 128'(64'h00000003_00000000));
`endif

    // annul during ON iteration 10
    b32.signed_div_i = 1'b0; b32.opdata1_i = 32'd1000; b32.opdata2_i = 32'd3;
    b32.start_i = 1'b1;
    saw_ready = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
      saw_ready |= b32.ready_o;
    end
    check("annul busy before", 128'(b32.busy_o), 128'(1));
    b32.annul_i = 1'b1; b32.start_i = 1'b0;
    @(posedge clk); #1;
    saw_ready |= b32.ready_o;
    b32.annul_i = 1'b0;
    check("annul idle", 128'({b32.busy_o, b32.ready_o, b32.result_o}), '0);
    check("annul no ready", 128'(saw_ready), '0);
    op32("9/3 after annul", 1'b0, 32'd9, 32'd3, res);
    check("9/3 const", 128'(res), 128'(64'h00000000_00000003));

    // asynchronous reset in the middle of ON
    b32.signed_div_i = 1'b0; b32.opdata1_i = 32'hDEAD_BEEF; b32.opdata2_i = 32'd13;
    b32.start_i = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async reset", 128'({b32.busy_o, b32.ready_o, b32.result_o}), '0);
    b32.signed_div_i = 1'b1; b32.opdata1_i = 32'h80000000; b32.opdata2_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("held in reset", 128'({b32.busy_o, b32.ready_o}), '0);
    rst = 1'b1;
    op32("min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, res);
    check("min/-1 const", 128'(res), 128'(64'h00000000_80000000));

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = rnd_op(32, 1'b0);
      b = rnd_op(32, 1'b1);
      op32("rand32", s, a[31:0], b[31:0], res);
    end
    for (int i = 0; i < 80; i++) begin
      s = 1'($urandom);
      a = rnd_op(8, 1'b0);
      b = rnd_op(8, 1'b1);
      op8("rand8", s, a[7:0], b[7:0]);
    end
    op64("min64/-1", 1'b1, 64'h8000_0000_0000_0000, '1);
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      a = rnd_op(64, 1'b0);
      b = rnd_op(64, 1'b1);
      op64("rand64", s, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
